// File: rtl/clock_display_pkg.sv
// ----------------------------------------------------------------------------
// clock_display_pkg
// Shared definitions for the alarm-clock display scanner:
//   - digit index constants DIG_H1..DIG_S0 (5..0), matching the bit positions
//     of the active-low digit enable bus
//   - segment constants (active-low, {g,f,e,d,c,b,a})
//   - 16-entry BCD-to-segment glyph table, dash for codes above 9
//   - packed snapshot type holding one frame's worth of time digits
// ----------------------------------------------------------------------------
package clock_display_pkg;

    localparam logic [2:0] DIG_H1 = 3'd5;
    localparam logic [2:0] DIG_H0 = 3'd4;
    localparam logic [2:0] DIG_M1 = 3'd3;
    localparam logic [2:0] DIG_M0 = 3'd2;
    localparam logic [2:0] DIG_S1 = 3'd1;
    localparam logic [2:0] DIG_S0 = 3'd0;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low glyphs, index = BCD code. A 7 lights only a, b and c.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

    // One coherent HH:MM:SS sample, 22 bits total.
    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } time_snap_t;

endpackage

// File: rtl/seg7_decode.sv
// ----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to seven-segment decoder, active-low outputs.
// Codes 10..15 render as a dash (segment g only).
// Ports:
//   bcd  in  4  digit code
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg7_decode
    import clock_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = GLYPH_TABLE[bcd];

endmodule

// File: rtl/clock_display_mux.sv
// ----------------------------------------------------------------------------
// clock_display_mux
// Six-digit multiplexed common-anode display scanner for the alarm clock.
// A frame walks digits H1 (5) down to S0 (0); the time digits are sampled
// into a snapshot only at the very end of a frame, so every frame shows one
// coherent time. Hour-tens leading-zero blanking and colon dots on H0/M0.
//
// Optional feature, enabled by defining CLOCK_DISP_BLINK_EN:
//   while alarm is high the digit enables blink with a half-period of
//   BLINK_DIV clocks; without the macro, alarm is ignored.
//
// Parameters:
//   SCAN_DIV   clk cycles each digit stays lit (1..255)
//   BLINK_DIV  clk cycles per blink half-period (1..255)
// Ports:
//   clk         in  1  system clock, rising edge
//   reset       in  1  asynchronous, active-high
//   h1          in  2  hour tens (BCD 0..2, 3 shows a dash)
//   h0,m1,m0,
//   s1,s0       in  4  hour ones, minute tens/ones, second tens/ones (BCD)
//   alarm       in  1  alarm active level
//   blank_lead  in  1  blank hour tens when it is zero (sampled live)
//   an          out 6  digit enables, active-low, bit 5 = H1 .. bit 0 = S0
//   seg         out 7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out 1  decimal point (colon), active-low
//   digit_idx   out 3  digit currently presented on an/seg
// ----------------------------------------------------------------------------
module clock_display_mux
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] h1,
    input  logic [3:0] h0,
    input  logic [3:0] m1,
    input  logic [3:0] m0,
    input  logic [3:0] s1,
    input  logic [3:0] s0,
    input  logic       alarm,
    input  logic       blank_lead,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit_idx
);

    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

    logic [7:0] scan_cnt;
    logic [2:0] idx;
    time_snap_t snap;

    logic       scan_last;
    logic       frame_end;

    assign scan_last = (scan_cnt == SCAN_LAST);
    assign frame_end = scan_last && (idx == DIG_S0);

    // ------------------------------------------------------------------
    // Scan counter, digit index and frame snapshot
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would chain updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= DIG_H1;
            snap     <= '0;
        end else begin
            if (scan_last) begin
                scan_cnt <= '0;
                idx      <= (idx == DIG_S0) ? DIG_H1 : idx - 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 8'd1;
            end
            // Captured on the same edge that wraps idx back to H1, so the
            // next frame starts with the fresh time and never mixes two.
            if (frame_end) begin
                snap <= {h1, h0, m1, m0, s1, s0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional alarm blink
    // ------------------------------------------------------------------
    logic dark;

`ifdef CLOCK_DISP_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [7:0] blink_cnt;
    logic       blink_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!alarm) begin
            // Held at zero so a new alarm always opens with the lit half.
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 8'd1;
        end
    end

    // alarm is used live so dropping it lights the display on the next edge.
    assign dark = alarm & blink_phase;
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic unused_alarm;
    assign unused_alarm = alarm;
    assign dark         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Digit mux (one decoder after the mux)
    // ------------------------------------------------------------------
    logic [3:0] digit_bcd;
    logic [6:0] digit_seg;

    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        digit_bcd = 4'hF;
        case (idx)
            DIG_H1:  digit_bcd = (snap.h1 == 2'd3) ? 4'hF : {2'b00, snap.h1};
            DIG_H0:  digit_bcd = snap.h0;
            DIG_M1:  digit_bcd = snap.m1;
            DIG_M0:  digit_bcd = snap.m0;
            DIG_S1:  digit_bcd = snap.s1;
            DIG_S0:  digit_bcd = snap.s0;
            default: digit_bcd = 4'hF;
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd (digit_bcd),
        .seg (digit_seg)
    );

    // ------------------------------------------------------------------
    // Next output values and output registers
    // ------------------------------------------------------------------
    logic       blank_h1;
    logic [5:0] an_next;
    logic       dp_next;

    assign blank_h1 = blank_lead && (snap.h1 == 2'd0) && (idx == DIG_H1);

    always_comb begin
        an_next = 6'h3F;
        if (!dark && !blank_h1 && (idx <= DIG_H1)) begin
            an_next = ~(6'b000001 << idx);
        end
    end

    // Colon dots sit after the hour ones and minute ones digits.
    assign dp_next = !((idx == DIG_H0) || (idx == DIG_M0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an        <= 6'h3F;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
            digit_idx <= DIG_H1;
        end else begin
            an        <= an_next;
            seg       <= digit_seg;
            dp        <= dp_next;
            digit_idx <= idx;
        end
    end

endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Multiplexed six-digit seven-segment scanner for the digital alarm clock. It takes the clock's BCD time digits (HH:MM:SS) and the alarm flag, and drives one common-anode digit at a time, with a frame-coherent snapshot, leading-zero blanking and colon dots. It sits between the timekeeping block and the board's display pins, in the same 10 Hz `clk` domain.

## Interface
- `SCAN_DIV`, default 1: `clk` cycles each digit stays lit; legal range 1..255.
- `BLINK_DIV`, default 5: `clk` cycles per blink half-period (1 Hz blink at 10 Hz `clk`); legal range 1..255.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `h1` input 2: hour tens, BCD 0..2.
- `h0`, `m1`, `m0`, `s1`, `s0` input 4 each: hour ones, minute tens/ones, second tens/ones, BCD.
- `alarm` input 1: alarm active flag, level.
- `blank_lead` input 1: when 1, blank the hour-tens digit when it is 0.
- `an` output 6: digit enables, active-low, one-hot or all-high. Bit 5 = H1 … bit 0 = S0.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` output 1: decimal point, active-low.
- `digit_idx` output 3: index of the digit currently being presented on `an`/`seg`, 5..0.

## Operation
- Scan counter `scan_cnt` counts 0..SCAN_DIV-1. At terminal count the internal index `idx` steps 5→4→3→2→1→0→5.
- Snapshot: all six digits are captured into a 22-bit snapshot register on the cycle where `idx==0` and `scan_cnt==SCAN_DIV-1`. The snapshot and `idx` update on the same edge, so a frame never mixes two times. Inputs are not sampled at any other time.
- Decode: BCD 0..9 maps to the standard glyphs; 7 lights a,b,c. Any value above 9, and `h1==3`, shows a dash (g only).
- Blanking: when `blank_lead==1` and the snapshot `h1==0`, `an[5]` stays high while `idx==5`. `blank_lead` is sampled live.
- Colon: `dp` is low while `idx` is 4 or 2, and high otherwise.

## Timing
- Reset values: `an=6'b111111`, `seg=7'h7F`, `dp=1`, `digit_idx=5`. Internal state: `idx=5`, `scan_cnt=0`, snapshot all zero, blink counter 0, blink phase 0.
- `an`, `seg`, `dp` and `digit_idx` are registered. The outputs at edge t+1 reflect `idx`, the snapshot and the live controls at t, giving one cycle of latency.
- The first frame after reset displays the zero snapshot (00:00:00, or blanked hour tens). The first capture happens at the end of the first frame, which is 6·SCAN_DIV cycles after reset release.
- Frame period is 6·SCAN_DIV cycles. A change on the digit inputs reaches the display at most 6·SCAN_DIV+1 cycles later.
- At any time, `an` has at most one bit low.
- Reset asserted mid-frame forces all reset values immediately, independent of `clk`.

## Configuration
- `CLOCK_DISP_BLINK_EN` defined:
  - While `alarm==1`, the blink counter counts 0..BLINK_DIV-1 and toggles the phase at terminal count.
  - While phase is 1, all `an` bits are high; `seg`, `dp` and the scan continue.
  - While `alarm==0`, the counter and phase are held at 0, so a blink always starts with the visible half.
- `CLOCK_DISP_BLINK_EN` not defined: there is no blink logic and `alarm` is ignored.

## Structure
- Shared package `clock_display_pkg` holds:
  - digit index constants `DIG_H1`..`DIG_S0` (5..0);
  - segment constants `SEG_BLANK` and `SEG_DASH`;
  - the 16-entry BCD-to-segment glyph table.
- Sub-module `seg7_decode`: combinational 4-bit BCD to 7-bit active-low segments, dash for values above 9. It is instantiated once, after the digit mux.

## Test plan
- Reset, then hold inputs at 12:34:56 with `SCAN_DIV=1`:
  - first frame: `an` walks 011111…111110 with zero glyphs (`seg=7'h40`);
  - second frame: 1,2,3,4,5,6 glyphs (`7'h79`, `7'h24`, `7'h30`, `7'h19`, `7'h12`, `7'h02`);
  - `dp` is low on `digit_idx` 4 and 2.
- Change `m0` 4→9 while the second frame is mid-scan (at `idx==2`): the second frame still shows 4; the third frame shows 9 (`7'h10`).
- Present `h1=0`, `h0=7` with `blank_lead=1`: `an` stays 111111 during `digit_idx==5`, and digit 4 shows `7'h78`. With `blank_lead=0`, digit 5 shows `7'h40`.
- Present `s0=4'hC` and `h1=3`: both digits show `7'h3F` (dash).
- With `CLOCK_DISP_BLINK_EN` and `BLINK_DIV=5`, raise `alarm`: `an` is active for 5 cycles, all-high for 5, and repeats. Drop `alarm` during the dark phase: the next cycle's registered `an` is active.
- Assert `reset` mid-scan at `idx==3`: outputs immediately become 111111/7F/1/5, and scanning restarts from digit 5 with the zero snapshot.
